time_counter: RTL

//  Time-of-day core placed directly downstream of the clock generator. Consumes the
//  0.5 s-toggle Clock_1Sec (rising edge = 1 s) and keeps HH:MM:SS in packed BCD, 24 h.
//  Two push-buttons (Mode, Inc) set hours/minutes via a 3-state mode FSM.

---
 rtl/time_counter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/time_counter.sv
// time_counter
//   24 h time-of-day core. Counts HH:MM:SS in packed BCD from the rising edges
//   of Clock_1Sec. Two debounced push-buttons set hours and minutes through a
//   three-state mode FSM (RUN -> SET_HOUR -> SET_MIN -> RUN).
//
// Ports
//   Clock_5K    in   5 kHz system clock, rising edge
//   Reset       in   asynchronous, active-low
//   Clock_1Sec  in   seconds clock from the clock generator (same domain)
//   Mode_Btn    in   raw mode button, active-high
//   Inc_Btn     in   raw increment button, active-high
//   Hour_BCD    out  hours 00-23, packed BCD
//   Min_BCD     out  minutes 00-59, packed BCD
//   Sec_BCD     out  seconds 00-59, packed BCD
//   Mode        out  00 RUN, 01 SET_HOUR, 10 SET_MIN
//   Sec_Tick    out  one-cycle pulse aligned with the seconds update
module time_counter #(
  parameter int DEBOUNCE_CYC = 50
) (
  input  logic       Clock_5K,
  input  logic       Reset,
  input  logic       Clock_1Sec,
  input  logic       Mode_Btn,
  input  logic       Inc_Btn,
  output logic [7:0] Hour_BCD,
  output logic [7:0] Min_BCD,
  output logic [7:0] Sec_BCD,
  output logic [1:0] Mode,
  output logic       Sec_Tick
);

  localparam int            CW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  // Packed-BCD increment that wraps to 00 after max_v; units 9 carries into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic          prev_r;
  logic          tick_s;
  logic [1:0]    raw_s;
  logic [1:0]    stable_r;
  logic [1:0]    press_r;
  logic [CW-1:0] cnt_r [2];
  mode_e         state_r;
  logic          mode_press_s;
  logic          inc_press_s;

  // Only rising edges of the seconds clock count; falling edges are ignored.
  assign tick_s       = Clock_1Sec & ~prev_r;
  assign raw_s        = {Inc_Btn, Mode_Btn};
  assign mode_press_s = press_r[0];
  assign inc_press_s  = press_r[1];
  assign Mode         = state_r;

  // Seconds edge detector and the registered tick pulse.
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) begin
      prev_r   <= 1'b0;
      Sec_Tick <= 1'b0;
    end else begin
      prev_r   <= Clock_1Sec;
      Sec_Tick <= tick_s;
    end
  end

  // Button debouncers: a level must persist DEBOUNCE_CYC samples to be
  // accepted; an accepted 0->1 transition yields a single press pulse.
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) begin
      stable_r <= 2'b00;
      press_r  <= 2'b00;
      cnt_r[0] <= '0;
      cnt_r[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press_r[i] <= 1'b0;
        if (raw_s[i] != stable_r[i]) begin
          if (cnt_r[i] == CNT_MAX) begin
            stable_r[i] <= raw_s[i];
            cnt_r[i]    <= '0;
            press_r[i]  <= raw_s[i];
          end else begin
            cnt_r[i] <= cnt_r[i] + CNT_ONE;
          end
        end else begin
          cnt_r[i] <= '0;
        end
      end
    end
  end

  // Mode FSM and time registers. In RUN a coincident Mode press still lets
  // the tick land; in SET_* Mode has priority over Inc and ticks are dropped.
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) begin
      state_r  <= RUN;
      Hour_BCD <= 8'h00;
      Min_BCD  <= 8'h00;
      Sec_BCD  <= 8'h00;
    end else begin
      case (state_r)
        RUN: begin
          if (tick_s) begin
            Sec_BCD <= bcd_inc(Sec_BCD, 8'h59);
            if (Sec_BCD == 8'h59) begin
              Min_BCD <= bcd_inc(Min_BCD, 8'h59);
              if (Min_BCD == 8'h59) begin
                Hour_BCD <= bcd_inc(Hour_BCD, 8'h23);
              end
            end
          end
          if (mode_press_s) begin
            state_r <= SET_HOUR;
          end
        end
        SET_HOUR: begin
          if (mode_press_s) begin
            state_r <= SET_MIN;
          end else if (inc_press_s) begin
            Hour_BCD <= bcd_inc(Hour_BCD, 8'h23);
          end
        end
        SET_MIN: begin
          if (mode_press_s) begin
            state_r <= RUN;
            Sec_BCD <= 8'h00;
          end else if (inc_press_s) begin
            Min_BCD <= bcd_inc(Min_BCD, 8'h59);
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

endmodule
